// File: rtl/corevx_mem_arbiter.sv
// corevx_mem_arbiter: shares one Avalon burst slave between icache (m0) and dcache (m1); grant held per burst.
// Latency: one arbitration cycle (request seen at edge T drives s_read/s_write from T+1); data paths combinational.
// Backpressure: s_waitrequest mirrored to the granted master only; the other master sees waitrequest=1.
// Option COREVX_ARB_ROUND_ROBIN_EN: round-robin between masters; undefined gives fixed priority to m0.
module corevx_mem_arbiter #(
    parameter int BURST_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    // master 0 (instruction cache)
    input  logic [33:0]        m0_address,
    input  logic [BURST_W-1:0] m0_burstcount,
    input  logic               m0_read,
    input  logic               m0_write,
    input  logic [31:0]        m0_writedata,
    input  logic [3:0]         m0_byteenable,
    output logic               m0_waitrequest,
    output logic [31:0]        m0_readdata,
    output logic               m0_readdatavalid,
    output logic [1:0]         m0_response,
    // master 1 (data cache)
    input  logic [33:0]        m1_address,
    input  logic [BURST_W-1:0] m1_burstcount,
    input  logic               m1_read,
    input  logic               m1_write,
    input  logic [31:0]        m1_writedata,
    input  logic [3:0]         m1_byteenable,
    output logic               m1_waitrequest,
    output logic [31:0]        m1_readdata,
    output logic               m1_readdatavalid,
    output logic [1:0]         m1_response,
    // slave port
    output logic [33:0]        s_address,
    output logic [BURST_W-1:0] s_burstcount,
    output logic               s_read,
    output logic               s_write,
    output logic [31:0]        s_writedata,
    output logic [3:0]         s_byteenable,
    input  logic               s_waitrequest,
    input  logic               s_readdatavalid,
    input  logic [31:0]        s_readdata,
    input  logic [1:0]         s_response
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_RDATA = 2'd2,
        ST_WDATA = 2'd3
    } state_t;

    localparam logic [BURST_W-1:0] ONE = {{(BURST_W-1){1'b0}}, 1'b1};

    state_t             r_state;
    state_t             w_next_state;
    logic               r_grant;
    logic [BURST_W-1:0] r_beats_left;
    logic [33:0]        r_addr;
    logic [BURST_W-1:0] r_bc;
`ifdef COREVX_ARB_ROUND_ROBIN_EN
    logic               r_last;
`endif

    logic [33:0]        w_g_addr;
    logic [BURST_W-1:0] w_g_bc_raw;
    logic [BURST_W-1:0] w_g_bc;
    logic               w_g_read;
    logic               w_g_write;
    logic [31:0]        w_g_wdata;
    logic [3:0]         w_g_be;
    logic               w_req0;
    logic               w_req1;
    logic               w_winner;
    logic               w_cmd_rd_acc;
    logic               w_cmd_wr_acc;
    logic               w_cmd_drop;
    logic               w_rd_beat;
    logic               w_wr_beat;
    logic               w_burst_done;
    logic               w_g_wait;
    logic               w_g_rdv;

    // Select the granted master's command and pick the next winner.
    always_comb begin
        w_g_addr   = r_grant ? m1_address    : m0_address;
        w_g_bc_raw = r_grant ? m1_burstcount : m0_burstcount;
        w_g_read   = r_grant ? m1_read       : m0_read;
        w_g_write  = r_grant ? m1_write      : m0_write;
        w_g_wdata  = r_grant ? m1_writedata  : m0_writedata;
        w_g_be     = r_grant ? m1_byteenable : m0_byteenable;
        // A zero burstcount is treated as a single beat.
        w_g_bc     = (w_g_bc_raw == '0) ? ONE : w_g_bc_raw;
        w_req0     = m0_read | m0_write;
        w_req1     = m1_read | m1_write;
`ifdef COREVX_ARB_ROUND_ROBIN_EN
        // Contention goes to whoever did not finish the previous burst.
        w_winner   = (w_req0 && w_req1) ? ~r_last : w_req1;
`else
        w_winner   = ~w_req0;
`endif
        w_cmd_rd_acc = (r_state == ST_CMD) && w_g_read && !s_waitrequest;
        w_cmd_wr_acc = (r_state == ST_CMD) && !w_g_read && w_g_write && !s_waitrequest;
        w_cmd_drop   = (r_state == ST_CMD) && !w_g_read && !w_g_write;
        w_rd_beat    = (r_state == ST_RDATA) && s_readdatavalid;
        w_wr_beat    = (r_state == ST_WDATA) && w_g_write && !s_waitrequest;
        w_burst_done = (w_cmd_wr_acc && (w_g_bc == ONE))
                     || ((w_rd_beat || w_wr_beat) && (r_beats_left == ONE));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_req0 || w_req1) w_next_state = ST_CMD;
            end
            ST_CMD: begin
                if (w_cmd_drop)        w_next_state = ST_IDLE;
                else if (w_cmd_rd_acc) w_next_state = ST_RDATA;
                else if (w_cmd_wr_acc) w_next_state = (w_g_bc == ONE) ? ST_IDLE : ST_WDATA;
            end
            ST_RDATA: begin
                if (w_rd_beat && (r_beats_left == ONE)) w_next_state = ST_IDLE;
            end
            ST_WDATA: begin
                if (w_wr_beat && (r_beats_left == ONE)) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Grant, beat counter and captured command; winner history updates only on completed bursts.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant      <= 1'b0;
            r_beats_left <= '0;
            r_addr       <= '0;
            r_bc         <= '0;
`ifdef COREVX_ARB_ROUND_ROBIN_EN
            r_last       <= 1'b1;
`endif
        end else begin
            if ((r_state == ST_IDLE) && (w_req0 || w_req1)) begin
                r_grant <= w_winner;
            end
            if (w_cmd_rd_acc) begin
                r_beats_left <= w_g_bc;
                r_addr       <= w_g_addr;
                r_bc         <= w_g_bc;
            end else if (w_cmd_wr_acc) begin
                r_beats_left <= w_g_bc - ONE;
                r_addr       <= w_g_addr;
                r_bc         <= w_g_bc;
            end else if (w_rd_beat || w_wr_beat) begin
                r_beats_left <= r_beats_left - ONE;
            end
`ifdef COREVX_ARB_ROUND_ROBIN_EN
            if (w_burst_done) begin
                r_last <= r_grant;
            end
`endif
        end
    end

    // Output decode: slave command, stall and read-return steering.
    always_comb begin
        s_address        = r_addr;
        s_burstcount     = r_bc;
        s_read           = 1'b0;
        s_write          = 1'b0;
        s_writedata      = w_g_wdata;
        s_byteenable     = w_g_be;
        w_g_wait         = 1'b1;
        w_g_rdv          = 1'b0;
        m0_readdatavalid = 1'b0;
        m0_readdata      = '0;
        m0_response      = 2'b00;
        m1_readdatavalid = 1'b0;
        m1_readdata      = '0;
        m1_response      = 2'b00;
        case (r_state)
            ST_CMD: begin
                s_address    = w_g_addr;
                s_burstcount = w_g_bc;
                s_read       = w_g_read;
                s_write      = w_g_write & ~w_g_read;
                w_g_wait     = s_waitrequest;
            end
            ST_RDATA: begin
                w_g_rdv = s_readdatavalid;
            end
            ST_WDATA: begin
                s_write  = w_g_write;
                w_g_wait = s_waitrequest;
            end
            default: begin
                s_read  = 1'b0;
            end
        endcase
        m0_waitrequest = r_grant ? 1'b1 : w_g_wait;
        m1_waitrequest = r_grant ? w_g_wait : 1'b1;
        if (w_g_rdv) begin
            if (r_grant) begin
                m1_readdatavalid = 1'b1;
                m1_readdata      = s_readdata;
                m1_response      = s_response;
            end else begin
                m0_readdatavalid = 1'b1;
                m0_readdata      = s_readdata;
                m0_response      = s_response;
            end
        end
    end

endmodule

// File: tb/tb_corevx_mem_arbiter.sv
// tb_corevx_mem_arbiter: directed scenarios for the two-master burst arbiter.
// Inputs change just after the falling edge; outputs are sampled 1 time unit later.
// Arbitration expectations follow COREVX_ARB_ROUND_ROBIN_EN when the bench is built with it.
module tb_corevx_mem_arbiter;
    localparam int BURST_W = 5;

    logic               clk = 1'b0;
    logic               rst;
    logic [33:0]        m0_address, m1_address, s_address;
    logic [BURST_W-1:0] m0_burstcount, m1_burstcount, s_burstcount;
    logic               m0_read, m0_write, m1_read, m1_write, s_read, s_write;
    logic [31:0]        m0_writedata, m1_writedata, s_writedata;
    logic [3:0]         m0_byteenable, m1_byteenable, s_byteenable;
    logic               m0_waitrequest, m1_waitrequest;
    logic [31:0]        m0_readdata, m1_readdata, s_readdata;
    logic               m0_readdatavalid, m1_readdatavalid;
    logic [1:0]         m0_response, m1_response, s_response;
    logic               s_waitrequest, s_readdatavalid;

    int  checks = 0;
    int  errors = 0;
    int  rd_acc_cnt = 0;
    int  wr_acc_cnt = 0;
    bit  rr;

    corevx_mem_arbiter #(.BURST_W(BURST_W)) dut (
        .clk(clk), .rst(rst),
        .m0_address(m0_address), .m0_burstcount(m0_burstcount), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid), .m0_response(m0_response),
        .m1_address(m1_address), .m1_burstcount(m1_burstcount), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid), .m1_response(m1_response),
        .s_address(s_address), .s_burstcount(s_burstcount), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable), .s_waitrequest(s_waitrequest),
        .s_readdatavalid(s_readdatavalid), .s_readdata(s_readdata), .s_response(s_response)
    );

    always #5 clk = ~clk;

    // Count commands the slave actually accepts.
    always @(posedge clk) begin
        if (!rst && s_read && !s_waitrequest)  rd_acc_cnt <= rd_acc_cnt + 1;
        if (!rst && s_write && !s_waitrequest) wr_acc_cnt <= wr_acc_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        m0_address = '0; m0_burstcount = '0; m0_read = 0; m0_write = 0; m0_writedata = '0; m0_byteenable = '0;
        m1_address = '0; m1_burstcount = '0; m1_read = 0; m1_write = 0; m1_writedata = '0; m1_byteenable = '0;
        s_waitrequest = 0; s_readdatavalid = 0; s_readdata = '0; s_response = 2'b00;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        m0_read = 1;
        repeat (2) step();
        #1;
        checks++; if (m0_waitrequest !== 1'b1) begin errors++; $display("FAIL rst_m0_wait: got %b want 1", m0_waitrequest); end
        checks++; if (m1_waitrequest !== 1'b1) begin errors++; $display("FAIL rst_m1_wait: got %b want 1", m1_waitrequest); end
        checks++; if (s_read !== 1'b0) begin errors++; $display("FAIL rst_s_read: got %b want 0", s_read); end
        checks++; if (s_write !== 1'b0) begin errors++; $display("FAIL rst_s_write: got %b want 0", s_write); end
        checks++; if (m0_readdatavalid !== 1'b0) begin errors++; $display("FAIL rst_m0_rdv: got %b want 0", m0_readdatavalid); end
        checks++; if (m0_response !== 2'b00) begin errors++; $display("FAIL rst_m0_resp: got %b want 00", m0_response); end
        step();
        rst = 0;
        m0_read = 0;
    endtask

    task automatic test_single_read();
        logic [31:0] exp_d;
        step(); m0_read = 1; m0_address = 34'h1000; m0_burstcount = 5'd4; #1;
        checks++; if (s_read !== 1'b0) begin errors++; $display("FAIL sr_arb_cycle: s_read got %b want 0", s_read); end
        step(); #1;
        checks++; if (s_read !== 1'b1) begin errors++; $display("FAIL sr_cmd_read: got %b want 1", s_read); end
        checks++; if (s_address !== 34'h1000) begin errors++; $display("FAIL sr_cmd_addr: got %h want 1000", s_address); end
        checks++; if (s_burstcount !== 5'd4) begin errors++; $display("FAIL sr_cmd_bc: got %0d want 4", s_burstcount); end
        checks++; if (m0_waitrequest !== 1'b0) begin errors++; $display("FAIL sr_m0_wait: got %b want 0", m0_waitrequest); end
        checks++; if (m1_waitrequest !== 1'b1) begin errors++; $display("FAIL sr_m1_wait: got %b want 1", m1_waitrequest); end
        step(); m0_read = 0;
        for (int i = 0; i < 4; i++) begin
            if (i != 0) step();
            exp_d = 32'hA0 + 32'(i);
            s_readdatavalid = 1; s_readdata = exp_d; #1;
            checks++; if (m0_readdatavalid !== 1'b1) begin errors++; $display("FAIL sr_beat%0d_vld: got %b want 1", i, m0_readdatavalid); end
            checks++; if (m0_readdata !== exp_d) begin errors++; $display("FAIL sr_beat%0d_data: got %h want %h", i, m0_readdata, exp_d); end
            checks++; if (m1_readdatavalid !== 1'b0) begin errors++; $display("FAIL sr_beat%0d_m1rdv: got %b want 0", i, m1_readdatavalid); end
        end
        step(); s_readdata = 32'hDEAD; #1;
        checks++; if (m0_readdatavalid !== 1'b0) begin errors++; $display("FAIL sr_idle_stray: got %b want 0", m0_readdatavalid); end
        checks++; if (m0_waitrequest !== 1'b1) begin errors++; $display("FAIL sr_idle_wait: got %b want 1", m0_waitrequest); end
        step(); s_readdatavalid = 0;
    endtask

    task automatic test_simultaneous();
        logic [33:0] exp_a;
        logic        got;
        step();
        m0_read = 1; m0_address = 34'h2000; m0_burstcount = 5'd1;
        m1_read = 1; m1_address = 34'h3000; m1_burstcount = 5'd1;
        step(); #1;
        checks++; if (s_address !== 34'h2000) begin errors++; $display("FAIL sim_first_addr: got %h want 2000", s_address); end
        checks++; if (m1_waitrequest !== 1'b1) begin errors++; $display("FAIL sim_first_m1wait: got %b want 1", m1_waitrequest); end
        step(); m0_read = 0; s_readdatavalid = 1; s_readdata = 32'h11; #1;
        checks++; if (m0_readdatavalid !== 1'b1) begin errors++; $display("FAIL sim_first_rdv: got %b want 1", m0_readdatavalid); end
        // m0 immediately requests again while m1 is still waiting
        step(); s_readdatavalid = 0; m0_read = 1; m0_address = 34'h2004; #1;
        checks++; if (s_read !== 1'b0) begin errors++; $display("FAIL sim_idle_gap: s_read got %b want 0", s_read); end
        step(); #1;
        exp_a = rr ? 34'h3000 : 34'h2004;
        checks++; if (s_address !== exp_a) begin errors++; $display("FAIL sim_second_addr: got %h want %h", s_address, exp_a); end
        checks++; if (m1_waitrequest !== !rr) begin errors++; $display("FAIL sim_second_m1wait: got %b want %b", m1_waitrequest, !rr); end
        step();
        if (rr) m1_read = 0; else m0_read = 0;
        s_readdatavalid = 1; s_readdata = 32'h22; #1;
        got = rr ? m1_readdatavalid : m0_readdatavalid;
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL sim_second_rdv: got %b want 1", got); end
        step(); s_readdatavalid = 0;
        step(); #1;
        exp_a = rr ? 34'h2004 : 34'h3000;
        checks++; if (s_address !== exp_a) begin errors++; $display("FAIL sim_third_addr: got %h want %h", s_address, exp_a); end
        step(); m0_read = 0; m1_read = 0; s_readdatavalid = 1; s_readdata = 32'h33; #1;
        got = rr ? m0_readdatavalid : m1_readdatavalid;
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL sim_third_rdv: got %b want 1", got); end
        step(); s_readdatavalid = 0;
    endtask

    task automatic test_write_burst();
        int w0;
        w0 = wr_acc_cnt;
        step();
        m1_write = 1; m1_address = 34'h4000; m1_burstcount = 5'd2; m1_writedata = 32'hD0; m1_byteenable = 4'hF;
        s_waitrequest = 1; #1;
        checks++; if (m1_waitrequest !== 1'b1) begin errors++; $display("FAIL wr_arb_wait: got %b want 1", m1_waitrequest); end
        step(); m0_read = 1; m0_address = 34'h9000; m0_burstcount = 5'd1;
        for (int i = 0; i < 3; i++) begin
            if (i != 0) step();
            #1;
            checks++; if (m1_waitrequest !== 1'b1) begin errors++; $display("FAIL wr_stall%0d_m1wait: got %b want 1", i, m1_waitrequest); end
            checks++; if (m0_waitrequest !== 1'b1) begin errors++; $display("FAIL wr_stall%0d_m0wait: got %b want 1", i, m0_waitrequest); end
        end
        checks++; if (s_write !== 1'b1) begin errors++; $display("FAIL wr_cmd_write: got %b want 1", s_write); end
        step(); s_waitrequest = 0; #1;
        checks++; if (m1_waitrequest !== 1'b0) begin errors++; $display("FAIL wr_accept_wait: got %b want 0", m1_waitrequest); end
        checks++; if (s_writedata !== 32'hD0) begin errors++; $display("FAIL wr_beat0_data: got %h want d0", s_writedata); end
        checks++; if (s_burstcount !== 5'd2) begin errors++; $display("FAIL wr_cmd_bc: got %0d want 2", s_burstcount); end
        step(); m1_writedata = 32'hD1; m1_address = 34'h3FFC; m1_burstcount = 5'd7; #1;
        checks++; if (s_write !== 1'b1) begin errors++; $display("FAIL wr_beat1_write: got %b want 1", s_write); end
        checks++; if (s_writedata !== 32'hD1) begin errors++; $display("FAIL wr_beat1_data: got %h want d1", s_writedata); end
        checks++; if (s_address !== 34'h4000) begin errors++; $display("FAIL wr_beat1_addr: got %h want 4000", s_address); end
        checks++; if (s_burstcount !== 5'd2) begin errors++; $display("FAIL wr_beat1_bc: got %0d want 2", s_burstcount); end
        checks++; if (m0_waitrequest !== 1'b1) begin errors++; $display("FAIL wr_beat1_m0wait: got %b want 1", m0_waitrequest); end
        step(); m1_write = 0; m0_read = 0; #1;
        checks++; if (s_write !== 1'b0) begin errors++; $display("FAIL wr_idle_write: got %b want 0", s_write); end
        checks++; if (wr_acc_cnt - w0 !== 2) begin errors++; $display("FAIL wr_beat_count: got %0d want 2", wr_acc_cnt - w0); end
    endtask

    task automatic test_error_response();
        step(); m0_read = 1; m0_address = 34'h5000; m0_burstcount = 5'd2;
        step(); #1;
        checks++; if (s_read !== 1'b1) begin errors++; $display("FAIL err_cmd_read: got %b want 1", s_read); end
        step(); m0_read = 0; s_readdatavalid = 1; s_readdata = 32'hE0; s_response = 2'b11; #1;
        checks++; if (m0_response !== 2'b11) begin errors++; $display("FAIL err_beat0_resp: got %b want 11", m0_response); end
        checks++; if (m0_readdatavalid !== 1'b1) begin errors++; $display("FAIL err_beat0_vld: got %b want 1", m0_readdatavalid); end
        step(); s_readdata = 32'hE1; s_response = 2'b00; #1;
        checks++; if (m0_response !== 2'b00) begin errors++; $display("FAIL err_beat1_resp: got %b want 00", m0_response); end
        checks++; if (m0_readdata !== 32'hE1) begin errors++; $display("FAIL err_beat1_data: got %h want e1", m0_readdata); end
        step(); s_readdatavalid = 0; m1_read = 1; m1_address = 34'h6000; m1_burstcount = 5'd1; #1;
        checks++; if (s_read !== 1'b0) begin errors++; $display("FAIL err_idle_read: got %b want 0", s_read); end
        step(); #1;
        checks++; if (s_address !== 34'h6000) begin errors++; $display("FAIL err_next_addr: got %h want 6000", s_address); end
        step(); m1_read = 0; s_readdatavalid = 1; s_readdata = 32'hF0; #1;
        checks++; if (m1_readdatavalid !== 1'b1) begin errors++; $display("FAIL err_next_rdv: got %b want 1", m1_readdatavalid); end
        step(); s_readdatavalid = 0;
    endtask

    task automatic test_reset_mid_burst();
        step(); m0_read = 1; m0_address = 34'h7000; m0_burstcount = 5'd4;
        step();
        step(); m0_read = 0; s_readdatavalid = 1; s_readdata = 32'hB0; #1;
        checks++; if (m0_readdatavalid !== 1'b1) begin errors++; $display("FAIL rmb_beat0_vld: got %b want 1", m0_readdatavalid); end
        step(); s_readdatavalid = 0; rst = 1;
        step(); rst = 0; s_readdatavalid = 1; s_readdata = 32'hB1;
        m1_read = 1; m1_address = 34'h7100; m1_burstcount = 5'd1; #1;
        checks++; if (m0_readdatavalid !== 1'b0) begin errors++; $display("FAIL rmb_late_beat: got %b want 0", m0_readdatavalid); end
        checks++; if (m0_waitrequest !== 1'b1) begin errors++; $display("FAIL rmb_idle_wait: got %b want 1", m0_waitrequest); end
        step(); s_readdata = 32'hB2; #1;
        checks++; if (m0_readdatavalid !== 1'b0) begin errors++; $display("FAIL rmb_cmd_m0rdv: got %b want 0", m0_readdatavalid); end
        checks++; if (m1_readdatavalid !== 1'b0) begin errors++; $display("FAIL rmb_cmd_m1rdv: got %b want 0", m1_readdatavalid); end
        checks++; if (s_address !== 34'h7100) begin errors++; $display("FAIL rmb_m1_addr: got %h want 7100", s_address); end
        checks++; if (m1_waitrequest !== 1'b0) begin errors++; $display("FAIL rmb_m1_wait: got %b want 0", m1_waitrequest); end
        step(); m1_read = 0; s_readdata = 32'hC0; #1;
        checks++; if (m1_readdata !== 32'hC0) begin errors++; $display("FAIL rmb_m1_data: got %h want c0", m1_readdata); end
        step(); s_readdatavalid = 0;
    endtask

    task automatic test_read_precedence_bc0();
        step(); m0_read = 1; m0_write = 1; m0_address = 34'hA000; m0_burstcount = 5'd0;
        step(); #1;
        checks++; if (s_read !== 1'b1) begin errors++; $display("FAIL prec_read: got %b want 1", s_read); end
        checks++; if (s_write !== 1'b0) begin errors++; $display("FAIL prec_write: got %b want 0", s_write); end
        checks++; if (s_burstcount !== 5'd1) begin errors++; $display("FAIL bc0_as_1: got %0d want 1", s_burstcount); end
        step(); m0_read = 0; m0_write = 0; s_readdatavalid = 1; s_readdata = 32'h55; #1;
        checks++; if (m0_readdatavalid !== 1'b1) begin errors++; $display("FAIL bc0_beat_vld: got %b want 1", m0_readdatavalid); end
        step(); s_readdata = 32'h66; #1;
        checks++; if (m0_readdatavalid !== 1'b0) begin errors++; $display("FAIL bc0_one_beat: got %b want 0", m0_readdatavalid); end
        step(); s_readdatavalid = 0;
    endtask

    task automatic test_abandoned();
        int          r0;
        logic [33:0] exp_a;
        logic        got;
        r0 = rd_acc_cnt;
        step(); m1_read = 1; m1_address = 34'hB000; m1_burstcount = 5'd1; s_waitrequest = 1;
        step(); m1_read = 0; #1;
        checks++; if (s_read !== 1'b0) begin errors++; $display("FAIL ab_cmd_read: got %b want 0", s_read); end
        checks++; if (m1_waitrequest !== 1'b1) begin errors++; $display("FAIL ab_cmd_wait: got %b want 1", m1_waitrequest); end
        step();
        m0_read = 1; m0_address = 34'hC000; m0_burstcount = 5'd1;
        m1_read = 1; s_waitrequest = 0; #1;
        checks++; if (s_read !== 1'b0) begin errors++; $display("FAIL ab_back_idle: s_read got %b want 0", s_read); end
        checks++; if (rd_acc_cnt !== r0) begin errors++; $display("FAIL ab_no_accept: got %0d want %0d", rd_acc_cnt, r0); end
        step(); #1;
        exp_a = rr ? 34'hB000 : 34'hC000;
        checks++; if (s_address !== exp_a) begin errors++; $display("FAIL ab_last_kept: got %h want %h", s_address, exp_a); end
        step(); m0_read = 0; m1_read = 0; s_readdatavalid = 1; s_readdata = 32'h77; #1;
        got = rr ? m1_readdatavalid : m0_readdatavalid;
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL ab_winner_rdv: got %b want 1", got); end
        step(); s_readdatavalid = 0;
    endtask

    initial begin
`ifdef COREVX_ARB_ROUND_ROBIN_EN
        rr = 1'b1;
`else
        rr = 1'b0;
`endif
        test_reset();
        test_single_read();
        test_simultaneous();
        test_write_burst();
        test_error_response();
        test_reset_mid_burst();
        test_read_precedence_bc0();
        test_abandoned();
        repeat (2) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
